// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory read at a time feeding a
// two-entry FIFO of {pc, instruction} toward the decoder, with redirect support.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic [1:0]  state_reg, state_next;
    logic [31:0] req_addr_reg, req_addr_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [1:0]  count_reg, count_next;
    logic        head_reg, head_next;
    logic [31:0] buf_pc_reg   [DEPTH];
    logic [31:0] buf_data_reg [DEPTH];

    logic        push;
    logic        pop;
    logic        wr_idx;
    logic [31:0] redirect_aligned;
    logic [31:0] pc_plus4;

    assign imem_read        = (state_reg != IDLE);
    assign imem_address     = req_addr_reg;
    assign inst_valid       = (count_reg != 2'd0);
    assign inst             = buf_data_reg[head_reg];
    assign inst_pc          = buf_pc_reg[head_reg];

    assign redirect_aligned = redirect_pc & ~32'h3;
    assign pc_plus4         = fetch_pc_reg + 32'd4;
    assign pop              = inst_valid & inst_ready & ~redirect;
    // A response is only kept when the request is live and no redirect kills it.
    assign push             = (state_reg == FETCH) & imem_resp & ~redirect;
    assign wr_idx           = head_reg ^ count_reg[0];

    always_comb begin
        state_next    = state_reg;
        req_addr_next = req_addr_reg;
        fetch_pc_next = fetch_pc_reg;
        count_next    = count_reg + {1'b0, push} - {1'b0, pop};
        head_next     = head_reg ^ pop;

        if (redirect) begin
            count_next    = 2'd0;
            fetch_pc_next = redirect_aligned;
        end else if (push) begin
            fetch_pc_next = pc_plus4;
        end

        case (state_reg)
            IDLE: begin
                if (redirect) begin
                    req_addr_next = redirect_aligned;
                    state_next    = FETCH;
                end else if (count_next < DEPTH_C) begin
                    req_addr_next = fetch_pc_reg;
                    state_next    = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    if (imem_resp) begin
                        req_addr_next = redirect_aligned;
                    end else begin
                        state_next = FLUSH;
                    end
                end else if (imem_resp) begin
                    req_addr_next = pc_plus4;
                    if (count_next >= DEPTH_C) begin
                        state_next = IDLE;
                    end
                end
            end
            FLUSH: begin
                // The stale response is swallowed; restart at the latest target.
                if (imem_resp) begin
                    req_addr_next = fetch_pc_next;
                    state_next    = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            req_addr_reg <= RESET_PC;
            fetch_pc_reg <= RESET_PC;
            count_reg    <= 2'd0;
            head_reg     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_reg[i]   <= '0;
                buf_data_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            req_addr_reg <= req_addr_next;
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            head_reg     <= head_next;
            if (push) begin
                buf_pc_reg[wr_idx]   <= fetch_pc_reg;
                buf_data_reg[wr_idx] <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, async reset sequence, then random
// traffic scored against an in-order instruction-stream model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(32'h00000060), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl [31];

    function automatic vec_t mk(logic resp, logic [31:0] rdata, logic ready, logic redir,
                                logic [31:0] rpc, logic e_read, logic [31:0] e_addr,
                                logic e_valid, logic [31:0] e_pc, logic [31:0] e_inst);
        vec_t v;
        v.resp = resp;     v.rdata = rdata;   v.ready = ready;   v.redir = redir;
        v.rpc = rpc;       v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc;     v.e_inst = e_inst;
        return v;
    endfunction

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] memf(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    int          lat;
    logic [31:0] held_addr;
    logic [31:0] exp_pc;
    logic        prev_hold;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    int          transfers;

    initial begin
        tbl[0]  = mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h60,       0, 32'h0,        32'h0);
        tbl[1]  = mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h60,       0, 32'h0,        32'h0);
        tbl[2]  = mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h60,       0, 32'h0,        32'h0);
        tbl[3]  = mk(1, 32'hD0D0D0D0, 1, 0, 32'h0,        1, 32'h60,       0, 32'h0,        32'h0);
        tbl[4]  = mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h64,       1, 32'h60,       32'hD0D0D0D0);
        tbl[5]  = mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h64,       0, 32'h0,        32'h0);
        tbl[6]  = mk(1, 32'hD1D1D1D1, 1, 0, 32'h0,        1, 32'h64,       0, 32'h0,        32'h0);
        tbl[7]  = mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h68,       1, 32'h64,       32'hD1D1D1D1);
        tbl[8]  = mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h68,       0, 32'h0,        32'h0);
        tbl[9]  = mk(1, 32'hD2D2D2D2, 1, 0, 32'h0,        1, 32'h68,       0, 32'h0,        32'h0);
        tbl[10] = mk(0, 32'h0,        0, 0, 32'h0,        1, 32'h6C,       1, 32'h68,       32'hD2D2D2D2);
        tbl[11] = mk(1, 32'hD3D3D3D3, 0, 0, 32'h0,        1, 32'h6C,       1, 32'h68,       32'hD2D2D2D2);
        tbl[12] = mk(0, 32'h0,        0, 0, 32'h0,        0, 32'h70,       1, 32'h68,       32'hD2D2D2D2);
        tbl[13] = mk(0, 32'h0,        0, 0, 32'h0,        0, 32'h70,       1, 32'h68,       32'hD2D2D2D2);
        tbl[14] = mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h70,       1, 32'h68,       32'hD2D2D2D2);
        tbl[15] = mk(0, 32'h0,        0, 0, 32'h0,        1, 32'h70,       1, 32'h6C,       32'hD3D3D3D3);
        tbl[16] = mk(0, 32'h0,        1, 1, 32'h200,      1, 32'h70,       1, 32'h6C,       32'hD3D3D3D3);
        tbl[17] = mk(1, 32'hBAD00000, 1, 0, 32'h0,        1, 32'h70,       0, 32'h0,        32'h0);
        tbl[18] = mk(1, 32'hD4D4D4D4, 1, 0, 32'h0,        1, 32'h200,      0, 32'h0,        32'h0);
        tbl[19] = mk(1, 32'hBAD11111, 1, 1, 32'h103,      1, 32'h204,      1, 32'h200,      32'hD4D4D4D4);
        tbl[20] = mk(1, 32'hD5D5D5D5, 1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h0);
        tbl[21] = mk(0, 32'h0,        1, 1, 32'hFFFFFFFC, 1, 32'h104,      1, 32'h100,      32'hD5D5D5D5);
        tbl[22] = mk(1, 32'hBAD22222, 1, 0, 32'h0,        1, 32'h104,      0, 32'h0,        32'h0);
        tbl[23] = mk(1, 32'hD6D6D6D6, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        32'h0);
        tbl[24] = mk(1, 32'hD7D7D7D7, 1, 0, 32'h0,        1, 32'h0,        1, 32'hFFFFFFFC, 32'hD6D6D6D6);
        tbl[25] = mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'hD7D7D7D7);
        tbl[26] = mk(0, 32'h0,        1, 1, 32'h300,      1, 32'h4,        0, 32'h0,        32'h0);
        tbl[27] = mk(0, 32'h0,        1, 1, 32'h404,      1, 32'h4,        0, 32'h0,        32'h0);
        tbl[28] = mk(1, 32'hBAD33333, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
        tbl[29] = mk(0, 32'h0,        1, 1, 32'h500,      1, 32'h404,      0, 32'h0,        32'h0);
        tbl[30] = mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h404,      0, 32'h0,        32'h0);

        rst_n       = 1'b0;
        imem_rdata  = '0;
        imem_resp   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_read",  32'(imem_read),  32'h0);
        chk("rst_addr",  imem_address,    32'h60);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst",  inst,            32'h0);
        chk("rst_pc",    inst_pc,         32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("row%0d_read", i),  32'(imem_read),  32'(tbl[i].e_read));
            chk($sformatf("row%0d_addr", i),  imem_address,    tbl[i].e_addr);
            chk($sformatf("row%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d_pc", i),   inst_pc, tbl[i].e_pc);
                chk($sformatf("row%0d_inst", i), inst,    tbl[i].e_inst);
            end
            imem_resp   = tbl[i].resp;
            imem_rdata  = tbl[i].rdata;
            inst_ready  = tbl[i].ready;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            $display("row %0d: read=%0d addr=%h valid=%0d pc=%h inst=%h", i, imem_read,
                     imem_address, inst_valid, inst_pc, inst);
        end

        // Asynchronous reset in the middle of a FLUSH, no clock edge in between.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_read",  32'(imem_read),  32'h0);
        chk("arst_addr",  imem_address,    32'h60);
        chk("arst_valid", 32'(inst_valid), 32'h0);
        chk("arst_inst",  inst,            32'h0);
        chk("arst_pc",    inst_pc,         32'h0);
        $display("async reset: read=%0d addr=%h valid=%0d", imem_read, imem_address, inst_valid);
        @(negedge clk);
        imem_resp  = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_read",  32'(imem_read),  32'h1);
        chk("post_rst_addr",  imem_address,    32'h60);
        chk("post_rst_valid", 32'(inst_valid), 32'h0);
        imem_resp = 1'b0;
        @(negedge clk);
        chk("late_resp_ignored", 32'(inst_valid), 32'h0);
        chk("post_rst_addr2",    imem_address,    32'h60);

        // Random traffic: delivered stream must be consecutive words from the last target.
        lat       = -1;
        held_addr = '0;
        exp_pc    = 32'h60;
        prev_hold = 1'b0;
        hold_pc   = '0;
        hold_inst = '0;
        transfers = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_hold) begin
                chk("hold_valid", 32'(inst_valid), 32'h1);
                chk("hold_pc",    inst_pc,         hold_pc);
                chk("hold_inst",  inst,            hold_inst);
            end
            if (imem_read) begin
                if (lat < 0) begin
                    lat       = int'($urandom_range(0, 2));
                    held_addr = imem_address;
                end else begin
                    chk("addr_stable", imem_address, held_addr);
                end
                if (lat == 0) begin
                    imem_resp  = 1'b1;
                    imem_rdata = memf(imem_address);
                    lat        = -1;
                end else begin
                    imem_resp  = 1'b0;
                    imem_rdata = $urandom;
                    lat--;
                end
            end else begin
                imem_resp = 1'b0;
                lat       = -1;
            end
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                                       : $urandom;
            inst_ready  = ($urandom_range(0, 9) < 7);
            if (inst_valid && inst_ready && !redirect) begin
                chk("rand_pc",   inst_pc, exp_pc);
                chk("rand_inst", inst,    memf(exp_pc));
                $display("xfer %0d: pc=%h inst=%h", transfers, inst_pc, inst);
                exp_pc = exp_pc + 32'd4;
                transfers++;
            end
            if (redirect) exp_pc = redirect_pc & ~32'h3;
            prev_hold = inst_valid && !inst_ready && !redirect;
            hold_pc   = inst_pc;
            hold_inst = inst;
        end
        chk("enough_transfers", (transfers >= 200) ? 32'h1 : 32'h0, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
